// File: rtl/eig_pkg.sv
// Shared types for the second-order eigenvalue solver: damping regime
// encoding, controller states and the fixed end-to-end latency.
package eig_pkg;

  typedef enum logic [2:0] {
    REG_NONE  = 3'b000,
    REG_UNDER = 3'b001,
    REG_CRIT  = 3'b010,
    REG_OVER  = 3'b100
  } regime_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_SQRT  = 3'd2,
    ST_SCALE = 3'd3,
    ST_RECIP = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  // Edges from the accepting edge to out_valid, with ena held high.
  function automatic int unsigned eig_latency(input int unsigned w);
    return (32'd2 * w) + 32'd4;
  endfunction

endpackage

// File: rtl/eig_isqrt.sv
// Restoring integer square root, one root bit per enabled cycle.
// i_start loads the radicand; o_last is high during the cycle whose
// edge retires the final root bit, so o_root is valid right after it.
module eig_isqrt
  import eig_pkg::*;
#(
  parameter int IW = 66
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_ena,
  input  logic            i_start,
  input  logic [IW-1:0]   i_rad,
  output logic [IW/2-1:0] o_root,
  output logic            o_last
);

  localparam int RW = IW / 2;
  localparam int CW = $clog2(RW + 1);

  logic [IW-1:0] r_rad;
  logic [RW-1:0] r_root;
  logic [RW:0]   r_rem;
  logic [CW-1:0] r_cnt;

  logic [RW+2:0] w_rem_sh;
  logic [RW+2:0] w_trial;
  logic          w_fit;

  assign w_rem_sh = {r_rem, r_rad[IW-1:IW-2]};
  assign w_trial  = {1'b0, r_root, 2'b01};
  assign w_fit    = (w_rem_sh >= w_trial);
  assign o_root   = r_root;
  assign o_last   = (r_cnt == CW'(1));

  // Load on start, then consume two radicand bits per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rad  <= {IW{1'b0}};
      r_root <= {RW{1'b0}};
      r_rem  <= {(RW+1){1'b0}};
      r_cnt  <= {CW{1'b0}};
    end else if (i_ena) begin
      if (i_start) begin
        r_rad  <= i_rad;
        r_root <= {RW{1'b0}};
        r_rem  <= {(RW+1){1'b0}};
        r_cnt  <= CW'(RW);
      end else if (r_cnt != {CW{1'b0}}) begin
        r_rad  <= {r_rad[IW-3:0], 2'b00};
        r_root <= {r_root[RW-2:0], w_fit};
        r_rem  <= w_fit ? (RW+1)'(w_rem_sh - w_trial) : (RW+1)'(w_rem_sh);
        r_cnt  <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/eig_solver.sv
// Eigen-structure of s^2 + a1*s + a0 in signed Q(W-F).F:
// kappa = sqrt(|a1^2 - 4*a0|)/2, inv_kappa = 1/kappa, neg_beta_h = -a1/2,
// plus the damping regime. Fixed latency of 2W+4 enabled edges.
// Optional build macro EIG_SOLVER_SAT_FLAG_EN adds the 'sat' output.
module eig_solver
  import eig_pkg::*;
#(
  parameter int W = 32,
  parameter int F = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a0,
  input  logic signed [W-1:0] a1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] kappa,
  output logic signed [W-1:0] inv_kappa,
  output logic signed [W-1:0] neg_beta_h,
  output logic [2:0]          regime,
  output logic                inv_invalid,
  output logic                busy
`ifdef EIG_SOLVER_SAT_FLAG_EN
  ,output logic               sat
`endif
);

  localparam int DW = 2 * W + 2;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0]   L_MAX      = {1'b0, {(W-1){1'b1}}};
  localparam logic [2*W-1:0] L_DIVIDEND = {{(2*W-1){1'b0}}, 1'b1} << (2 * F);
  localparam logic [W-1:0]   L_N_HI     = L_DIVIDEND[2*W-1:W];
  localparam logic [W-1:0]   L_N_LO     = L_DIVIDEND[W-1:0];

  state_e              r_state, w_next;
  logic signed [W-1:0] r_a0, r_a1;
  regime_e             r_regime, w_regime;
  logic [W-1:0]        r_nbh, r_kappa, r_rem, r_quo;
  logic                r_dovf;
  logic [CW-1:0]       r_cnt;
  logic                r_out_valid, r_invalid_o;
  logic [W-1:0]        r_kappa_o, r_inv_o, r_nbh_o;
  logic [2:0]          r_regime_o;
`ifdef EIG_SOLVER_SAT_FLAG_EN
  logic                r_ksat, r_sat_o;
`endif

  logic                  w_accept, w_sq_start, w_sq_last, w_d_neg, w_d_zero;
  logic signed [2*W-1:0] w_a1x, w_a1sq;
  logic signed [2*W+2:0] w_a0x, w_d;
  logic [DW-1:0]         w_abs_d;
  logic signed [W:0]     w_nega;
  logic [W-1:0]          w_nbh, w_kappa_c;
  logic [W:0]            w_root, w_rem_sh;
  logic                  w_dfit, w_quo_ovf, w_kappa_zero;

  assign in_ready    = ena && (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign w_accept    = in_valid && in_ready;
  assign w_sq_start  = (r_state == ST_PREP);
  assign out_valid   = r_out_valid;
  assign kappa       = r_kappa_o;
  assign inv_kappa   = r_inv_o;
  assign neg_beta_h  = r_nbh_o;
  assign regime      = r_regime_o;
  assign inv_invalid = r_invalid_o;
`ifdef EIG_SOLVER_SAT_FLAG_EN
  assign sat         = r_sat_o;
`endif

  // Discriminant in Q.2F: a1^2 - 4*a0 with three guard bits, never overflows.
  assign w_a1x    = {{W{r_a1[W-1]}}, r_a1};
  assign w_a1sq   = w_a1x * w_a1x;
  assign w_a0x    = {{(W+3){r_a0[W-1]}}, r_a0};
  assign w_d      = {{3{w_a1sq[2*W-1]}}, w_a1sq} - (w_a0x <<< (F + 2));
  assign w_d_neg  = w_d[2*W+2];
  assign w_d_zero = (w_d == {(2*W+3){1'b0}});
  assign w_abs_d  = DW'(w_d_neg ? -w_d : w_d);

  // Half of -a1 computed one bit wider so a1 = -2^(W-1) stays exact.
  assign w_nega   = -$signed({r_a1[W-1], r_a1});
  assign w_nbh    = W'(w_nega >>> 1);

  // Root of the Q.2F magnitude is already Q.F; halving gives kappa.
  assign w_kappa_c = w_root[W] ? L_MAX : W'(w_root >> 1);

  // One restoring-division step of 2^(2F) / kappa.
  assign w_rem_sh     = {r_rem, r_quo[W-1]};
  assign w_dfit       = (w_rem_sh >= {1'b0, r_kappa});
  assign w_quo_ovf    = r_dovf | r_quo[W-1];
  assign w_kappa_zero = (r_kappa == {W{1'b0}});

  eig_isqrt #(.IW(DW)) u_isqrt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_ena   (ena),
    .i_start (w_sq_start),
    .i_rad   (w_abs_d),
    .o_root  (w_root),
    .o_last  (w_sq_last)
  );

  // Classify damping from the sign of the discriminant.
  always_comb begin
    w_regime = REG_NONE;
    if (w_d_neg) begin
      w_regime = REG_UNDER;
    end else if (w_d_zero) begin
      w_regime = REG_CRIT;
    end else begin
      w_regime = REG_OVER;
    end
  end

  // Controller state register, frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (ena) begin
      r_state <= w_next;
    end
  end

  // Next-state sequencing: fixed-length walk through every stage.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = w_accept ? ST_PREP : ST_IDLE;
      ST_PREP:  w_next = ST_SQRT;
      ST_SQRT:  w_next = w_sq_last ? ST_SCALE : ST_SQRT;
      ST_SCALE: w_next = ST_RECIP;
      ST_RECIP: w_next = (r_cnt == CW'(1)) ? ST_HOLD : ST_RECIP;
      ST_HOLD:  w_next = (r_out_valid && out_ready) ? ST_IDLE : ST_HOLD;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Operand capture, per-stage datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a0        <= {W{1'b0}};
      r_a1        <= {W{1'b0}};
      r_regime    <= REG_NONE;
      r_nbh       <= {W{1'b0}};
      r_kappa     <= {W{1'b0}};
      r_rem       <= {W{1'b0}};
      r_quo       <= {W{1'b0}};
      r_dovf      <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_out_valid <= 1'b0;
      r_kappa_o   <= {W{1'b0}};
      r_inv_o     <= {W{1'b0}};
      r_nbh_o     <= {W{1'b0}};
      r_regime_o  <= 3'b000;
      r_invalid_o <= 1'b0;
`ifdef EIG_SOLVER_SAT_FLAG_EN
      r_ksat      <= 1'b0;
      r_sat_o     <= 1'b0;
`endif
    end else if (ena) begin
      if (w_accept) begin
        r_a0 <= a0;
        r_a1 <= a1;
      end
      case (r_state)
        ST_PREP: begin
          r_regime <= w_regime;
          r_nbh    <= w_nbh;
        end
        ST_SCALE: begin
          r_kappa <= w_kappa_c;
          r_rem   <= L_N_HI;
          r_quo   <= L_N_LO;
          r_dovf  <= (L_N_HI >= w_kappa_c);
          r_cnt   <= CW'(W);
`ifdef EIG_SOLVER_SAT_FLAG_EN
          r_ksat  <= w_root[W];
`endif
        end
        ST_RECIP: begin
          r_rem <= w_dfit ? W'(w_rem_sh - {1'b0, r_kappa}) : W'(w_rem_sh);
          r_quo <= {r_quo[W-2:0], w_dfit};
          r_cnt <= r_cnt - CW'(1);
        end
        ST_HOLD: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_kappa_o   <= r_kappa;
            r_inv_o     <= (w_kappa_zero || w_quo_ovf) ? L_MAX : r_quo;
            r_nbh_o     <= r_nbh;
            r_regime_o  <= r_regime;
            r_invalid_o <= w_kappa_zero;
`ifdef EIG_SOLVER_SAT_FLAG_EN
            r_sat_o     <= r_ksat | (w_quo_ovf & ~w_kappa_zero);
`endif
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eig_solver.sv
// Directed, table-driven bench for eig_solver (W=32, F=16).
module tb_eig_solver;
  import eig_pkg::*;

  localparam int W = 32;
  localparam int F = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                ena = 1'b0;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] a0 = '0;
  logic signed [W-1:0] a1 = '0;
  logic                in_ready, out_valid, inv_invalid, busy;
  logic signed [W-1:0] kappa, inv_kappa, neg_beta_h;
  logic [2:0]          regime;
`ifdef EIG_SOLVER_SAT_FLAG_EN
  logic                sat;
`endif

  always #5 clk = ~clk;

  eig_solver #(.W(W), .F(F)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .a0(a0), .a1(a1),
    .out_valid(out_valid), .out_ready(out_ready),
    .kappa(kappa), .inv_kappa(inv_kappa), .neg_beta_h(neg_beta_h),
    .regime(regime), .inv_invalid(inv_invalid), .busy(busy)
`ifdef EIG_SOLVER_SAT_FLAG_EN
    , .sat(sat)
`endif
  );

  typedef struct {
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [2:0]   regime;
    logic [W-1:0] kappa;
    logic [W-1:0] inv;
    logic [W-1:0] nbh;
    logic         invalid;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;
  int   lat;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] x0, input logic [W-1:0] x1);
    int n;
    @(negedge clk);
    a0 = x0;
    a1 = x1;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int gap_at, output int l);
    l = 0;
    while (l < 300) begin
      @(posedge clk);
      #1;
      l++;
      if (l == gap_at) ena = 1'b0;
      if (l == gap_at + 5) ena = 1'b1;
      if (out_valid) break;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic check_res(input int i);
    chk($sformatf("v%0d_regime", i), regime, vecs[i].regime);
    chk($sformatf("v%0d_kappa", i), kappa, vecs[i].kappa);
    chk($sformatf("v%0d_inv_kappa", i), inv_kappa, vecs[i].inv);
    chk($sformatf("v%0d_neg_beta_h", i), neg_beta_h, vecs[i].nbh);
    chk($sformatf("v%0d_inv_invalid", i), inv_invalid, vecs[i].invalid);
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_after_ready", busy, 0);
    chk("valid_drop_after_ready", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         a0            a1            regime  kappa         inv           nbh           invalid
    vecs[0] = '{32'h00010000, 32'h00000000, 3'b001, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0};
    vecs[1] = '{32'h00010000, 32'h00020000, 3'b010, 32'h00000000, 32'h7FFFFFFF, 32'hFFFF0000, 1'b1};
    vecs[2] = '{32'h00000000, 32'h00040000, 3'b100, 32'h00020000, 32'h00008000, 32'hFFFE0000, 1'b0};
    vecs[3] = '{32'h00000000, 32'h00000000, 3'b010, 32'h00000000, 32'h7FFFFFFF, 32'h00000000, 1'b1};
    vecs[4] = '{32'hFFFD0000, 32'h00020000, 3'b100, 32'h00020000, 32'h00008000, 32'hFFFF0000, 1'b0};
    vecs[5] = '{32'h00040000, 32'h00000000, 3'b001, 32'h00020000, 32'h00008000, 32'h00000000, 1'b0};
    vecs[6] = '{32'h00000000, 32'h80000000, 3'b100, 32'h40000000, 32'h00000004, 32'h40000000, 1'b0};
    vecs[7] = '{32'h00000000, 32'h00000002, 3'b100, 32'h00000001, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[8] = '{32'hFFFFFFFF, 32'h00000000, 3'b100, 32'h00000100, 32'h01000000, 32'h00000000, 1'b0};
    vecs[9] = '{32'h00010000, 32'h00030000, 3'b100, 32'h00011E37, 32'h0000E4F9, 32'hFFFE8000, 1'b0};

    // Reset state.
    ena = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_kappa", kappa, 0);
    chk("rst_inv_kappa", inv_kappa, 0);
    chk("rst_regime", regime, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of operands: results and fixed latency.
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a0, vecs[i].a1);
      wait_valid(-100, lat);
      chk($sformatf("v%0d_latency", i), lat, eig_latency(W));
      check_res(i);
      release_op();
    end

    // Asynchronous reset in the middle of SQRT, then a clean operand.
    start_op(vecs[0].a0, vecs[0].a1);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_kappa", kappa, 0);
    chk("arst_inv_kappa", inv_kappa, 0);
    chk("arst_neg_beta_h", neg_beta_h, 0);
    chk("arst_regime", regime, 0);
    chk("arst_inv_invalid", inv_invalid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(vecs[2].a0, vecs[2].a1);
    wait_valid(-100, lat);
    chk("after_rst_latency", lat, eig_latency(W));
    check_res(2);
    release_op();

    // Back-pressure: results held for 10 cycles, new in_valid ignored.
    start_op(vecs[0].a0, vecs[0].a1);
    wait_valid(-100, lat);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        a0 = vecs[2].a0;
        a1 = vecs[2].a1;
        in_valid = 1'b1;
      end
      if (k == 5) in_valid = 1'b0;
      chk($sformatf("hold%0d_out_valid", k), out_valid, 1);
      chk($sformatf("hold%0d_in_ready", k), in_ready, 0);
      chk($sformatf("hold%0d_kappa", k), kappa, vecs[0].kappa);
      chk($sformatf("hold%0d_inv_kappa", k), inv_kappa, vecs[0].inv);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_res(0);
    release_op();

    // Five stalled cycles during RECIP stretch the latency by five.
    start_op(vecs[0].a0, vecs[0].a1);
    wait_valid(45, lat);
    chk("stall_latency", lat, eig_latency(W) + 5);
    check_res(0);
    release_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
